// File: rtl/instn_cache.sv
// Read-only direct-mapped instruction cache with whole-line refill.
// Hits return data combinationally; misses stall while the line is fetched.
//
// Ports:
//   clk, rstn      : clock, synchronous active-high reset
//   proc_rd_addr   : fetch word address
//   proc_rd_en     : fetch request
//   proc_rd_data   : hit data (0 when not hitting)
//   proc_rd_hit    : combinational hit flag
//   proc_busy      : refill in progress
//   mem_rd_data    : memory read data
//   mem_rd_valid   : memory able to deliver data
//   mem_rd_addr    : registered memory word address
//   mem_rd_en      : registered memory read request
module instn_cache #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int LINE_WIDTH  = 4,
  parameter int NUM_SETS    = 128,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] proc_rd_addr,
  input  logic                  proc_rd_en,
  output logic [DATA_WIDTH-1:0] proc_rd_data,
  output logic                  proc_rd_hit,
  output logic                  proc_busy,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  mem_rd_en
);

  localparam int OFFS_BITS = $clog2(LINE_WIDTH);
  localparam int IDX_BITS  = $clog2(NUM_SETS);
  localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - OFFS_BITS;
  localparam int WAIT_BITS = $clog2(MEM_LATENCY + 1);

  typedef enum logic {
    IDLE,
    REFILL
  } state_t;

  state_t state, state_nxt;

  logic [OFFS_BITS-1:0] req_offs;
  logic [IDX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]  req_tag;

  logic [DATA_WIDTH-1:0] data_mem [NUM_SETS][LINE_WIDTH];
  logic [TAG_BITS-1:0]   tag_mem  [NUM_SETS];
  logic [NUM_SETS-1:0]   valid_q;

  logic [TAG_BITS-1:0]  fill_tag;
  logic [IDX_BITS-1:0]  fill_idx;
  logic [OFFS_BITS-1:0] word_cnt;
  logic [OFFS_BITS-1:0] word_nxt;
  logic [WAIT_BITS-1:0] wait_cnt;

  logic lookup_hit;
  logic miss;
  logic word_done;
  logic last_word;

  assign req_offs = proc_rd_addr[OFFS_BITS-1:0];
  assign req_idx  = proc_rd_addr[OFFS_BITS+:IDX_BITS];
  assign req_tag  = proc_rd_addr[ADDR_WIDTH-1-:TAG_BITS];

  assign lookup_hit = proc_rd_en
                   && (state == IDLE)
                   && valid_q[req_idx]
                   && (tag_mem[req_idx] == req_tag);

  assign miss = proc_rd_en && (state == IDLE) && !lookup_hit;

  // A word is taken only once the latency window has fully elapsed.
  assign word_done = (state == REFILL)
                  && (wait_cnt == WAIT_BITS'(MEM_LATENCY))
                  && mem_rd_valid;

  assign last_word = (word_cnt == OFFS_BITS'(LINE_WIDTH - 1));
  assign word_nxt  = word_cnt + OFFS_BITS'(1);

  always_ff @(posedge clk) begin
    if (rstn) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (miss) state_nxt = REFILL;
      REFILL:  if (word_done && last_word) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    proc_busy    = (state == REFILL);
    proc_rd_hit  = lookup_hit;
    proc_rd_data = '0;
    if (lookup_hit) proc_rd_data = data_mem[req_idx][req_offs];
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      valid_q     <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      word_cnt    <= '0;
      wait_cnt    <= '0;
      fill_tag    <= '0;
      fill_idx    <= '0;
    end else if (miss) begin
      // Line is invalid while it is being overwritten.
      fill_tag          <= req_tag;
      fill_idx          <= req_idx;
      valid_q[req_idx]  <= 1'b0;
      mem_rd_addr       <= {req_tag, req_idx, {OFFS_BITS{1'b0}}};
      mem_rd_en         <= 1'b1;
      word_cnt          <= '0;
      wait_cnt          <= '0;
    end else if (state == REFILL) begin
      if (word_done) begin
        if (last_word) begin
          valid_q[fill_idx] <= 1'b1;
          mem_rd_en         <= 1'b0;
        end else begin
          word_cnt    <= word_nxt;
          mem_rd_addr <= {fill_tag, fill_idx, word_nxt};
          wait_cnt    <= '0;
        end
      end else if (wait_cnt != WAIT_BITS'(MEM_LATENCY)) begin
        wait_cnt <= wait_cnt + WAIT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn && word_done) begin
      data_mem[fill_idx][word_cnt] <= mem_rd_data;
      if (last_word) tag_mem[fill_idx] <= fill_tag;
    end
  end

endmodule

// File: tb/tb_instn_cache.sv
// Directed bench for instn_cache with a squaring memory model.
// Expected hit data is queued on request and popped on hit.
module tb_instn_cache;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [15:0] proc_rd_addr = '0;
  logic        proc_rd_en = 1'b0;
  logic [31:0] proc_rd_data;
  logic        proc_rd_hit;
  logic        proc_busy;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid = 1'b1;
  logic [15:0] mem_rd_addr;
  logic        mem_rd_en;

  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;

  int tests = 0;
  int fails = 0;
  int lat;
  int misses;
  int bad;
  logic [31:0] sb[$];
  logic [15:0] trace[$];

  instn_cache dut (
    .clk          (clk),
    .rstn         (rstn),
    .proc_rd_addr (proc_rd_addr),
    .proc_rd_en   (proc_rd_en),
    .proc_rd_data (proc_rd_data),
    .proc_rd_hit  (proc_rd_hit),
    .proc_busy    (proc_busy),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_en    (mem_rd_en)
  );

  always #5 clk = ~clk;

  // Memory: data for an address appears two edges after it is presented.
  always @(posedge clk) begin
    d1 <= 32'(mem_rd_addr) * 32'(mem_rd_addr);
    d2 <= d1;
  end
  assign mem_rd_data = d2;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue a read and wait for its hit. stall>0 holds mem_rd_valid low
  // for that many cycles; sw_at>0 retargets the request to a2 mid-way.
  task automatic do_read(input logic [15:0] a,
                         input int stall,
                         input int sw_at,
                         input logic [15:0] a2,
                         output int n);
    logic [31:0] exp;
    trace.delete();
    bad = 0;
    n = 0;
    @(posedge clk);
    #1;
    if (stall > 0) mem_rd_valid = 1'b0;
    proc_rd_addr = a;
    proc_rd_en   = 1'b1;
    sb.push_back(32'(a) * 32'(a));
    forever begin
      @(negedge clk);
      if (proc_busy) begin
        trace.push_back(mem_rd_addr);
        if (!mem_rd_en || proc_rd_hit) bad++;
      end
      if (proc_rd_hit) break;
      if (n >= 300) break;
      @(posedge clk);
      n++;
      #1;
      if (n == stall) mem_rd_valid = 1'b1;
      if (n == sw_at) begin
        proc_rd_addr = a2;
        if (sb.size() > 0) void'(sb.pop_back());
        sb.push_back(32'(a2) * 32'(a2));
      end
    end
    if (proc_rd_hit) begin
      exp = (sb.size() > 0) ? sb.pop_front() : 32'hdeadbeef;
      check($sformatf("data@%0d", proc_rd_addr), proc_rd_data, exp);
    end else begin
      tests++;
      fails++;
      $error("FAIL timeout: no hit for addr %0d after %0d cycles", a, n);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    check("refill_flags", 32'(bad), 0);
    proc_rd_en = 1'b0;
  endtask

  initial begin
    rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    proc_rd_addr = 16'd3;
    proc_rd_en   = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(proc_busy), 0);
    check("rst_mem_en", 32'(mem_rd_en), 0);
    check("rst_mem_addr", 32'(mem_rd_addr), 0);
    check("rst_hit", 32'(proc_rd_hit), 0);
    proc_rd_en = 1'b0;

    // Cold miss on address 3
    do_read(16'd3, 0, 0, 16'd0, lat);
    check("miss3_lat", 32'(lat), 13);
    check("miss3_trace_len", 32'(trace.size()), 12);
    for (int i = 0; i < 12; i++)
      check($sformatf("miss3_trace%0d", i), 32'(trace[i]), 32'(i / 3));
    check("miss3_mem_en_after", 32'(mem_rd_en), 0);
    for (int a = 0; a < 3; a++) begin
      do_read(16'(a), 0, 0, 16'd0, lat);
      check($sformatf("hit%0d_lat", a), 32'(lat), 0);
    end

    // Sequential stride-3 walk: lines 4,8,12,16,20,24 are new
    misses = 0;
    for (int a = 0; a <= 27; a += 3) begin
      do_read(16'(a), 0, 0, 16'd0, lat);
      if (lat > 0) misses++;
    end
    check("seq_misses", 32'(misses), 6);

    // Conflict miss on index 0
    do_read(16'd512, 0, 0, 16'd0, lat);
    check("conf_lat", 32'(lat), 13);
    check("conf_first", 32'(trace[0]), 512);
    check("conf_last", 32'(trace[11]), 515);
    do_read(16'd0, 0, 0, 16'd0, lat);
    check("evict_lat", 32'(lat), 13);
    check("evict_first", 32'(trace[0]), 0);
    check("evict_last", 32'(trace[11]), 3);

    // Memory stalled for 10 cycles at start of miss
    do_read(16'd40, 10, 0, 16'd0, lat);
    check("stall_lat", 32'(lat), 20);
    for (int i = 0; i < 10; i++)
      check($sformatf("stall_hold%0d", i), 32'(trace[i]), 40);

    // Request retargeted mid-refill
    do_read(16'd44, 0, 5, 16'd48, lat);
    check("sw_lat", 32'(lat), 26);
    check("sw_len", 32'(trace.size()), 24);
    check("sw_t0", 32'(trace[0]), 44);
    check("sw_t11", 32'(trace[11]), 47);
    check("sw_t12", 32'(trace[12]), 48);
    check("sw_t23", 32'(trace[23]), 51);
    do_read(16'd44, 0, 0, 16'd0, lat);
    check("sw_old_hit_lat", 32'(lat), 0);

    // Reset in the middle of a refill
    @(posedge clk);
    #1;
    proc_rd_addr = 16'd60;
    proc_rd_en   = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(proc_busy), 1);
    rstn = 1'b1;
    proc_rd_en = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(proc_busy), 0);
    check("mid_rst_mem_en", 32'(mem_rd_en), 0);
    do_read(16'd3, 0, 0, 16'd0, lat);
    check("post_rst_lat", 32'(lat), 13);

    check("sb_empty", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
